// File: rtl/pif_led_pattern.sv
// LED pattern generator: prescaled flash phase plus per-LED 8-bit PWM with shadowed duties.
// Define LED_BREATHE_EN to build the breathe FSM and level scaler for MODE_BREATHE.
module pif_led_pattern #(
  parameter int unsigned PRESCALE     = 1024,
  parameter int unsigned FLASH_TICKS  = 256,
  parameter logic [3:0]  MODE_OFF     = 4'd0,
  parameter logic [3:0]  MODE_ALT     = 4'd1,
  parameter logic [3:0]  MODE_SYNC    = 4'd2,
  parameter logic [3:0]  MODE_SOLID   = 4'd3,
  parameter logic [3:0]  MODE_BREATHE = 4'd4
) (
  input  logic       xclk,
  input  logic       sys_rst,
  input  logic [3:0] mode,
  input  logic [7:0] bright_r,
  input  logic [7:0] bright_g,
  output logic       red,
  output logic       green,
  output logic       phase
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
  localparam logic [15:0] FL_LAST  = 16'(FLASH_TICKS - 1);

  logic [15:0] pre_cnt_q, pre_cnt_d;
  logic [15:0] fl_cnt_q, fl_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  sh_r_q, sh_r_d;
  logic [7:0]  sh_g_q, sh_g_d;
  logic [3:0]  mode_q, mode_d;
  logic        phase_q, phase_d;
  logic        red_q, red_d;
  logic        green_q, green_d;
  logic        tick, mode_chg, pwm_r, pwm_g;
  logic [7:0]  duty_r, duty_g;

`ifdef LED_BREATHE_EN
  typedef enum logic {BR_UP = 1'b0, BR_DOWN = 1'b1} br_state_e;
  br_state_e   br_state_q, br_state_d;
  logic [7:0]  level_q, level_d;
`endif

  always_comb begin
    tick      = (pre_cnt_q == PRE_LAST);
    mode_chg  = (mode != mode_q);
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    pwm_r     = (sh_r_q > pwm_cnt_q);
    pwm_g     = (sh_g_q > pwm_cnt_q);

    mode_d    = mode_q;
    pre_cnt_d = tick ? '0 : pre_cnt_q + 16'd1;
    fl_cnt_d  = fl_cnt_q;
    phase_d   = phase_q;
    if (tick) begin
      if (fl_cnt_q == FL_LAST) begin
        fl_cnt_d = '0;
        phase_d  = ~phase_q;
      end else begin
        fl_cnt_d = fl_cnt_q + 16'd1;
      end
    end

    duty_r = bright_r;
    duty_g = bright_g;
`ifdef LED_BREATHE_EN
    level_d    = level_q;
    br_state_d = br_state_q;
    if (tick && (mode_q == MODE_BREATHE)) begin
      if (br_state_q == BR_UP) begin
        level_d = level_q + 8'd1;
        if (level_q == 8'd254) br_state_d = BR_DOWN;
      end else begin
        level_d = level_q - 8'd1;
        if (level_q == 8'd1) br_state_d = BR_UP;
      end
    end
    if (mode_q == MODE_BREATHE) begin
      duty_r = 8'((16'(bright_r) * 16'(level_q)) >> 8);
      duty_g = 8'((16'(bright_g) * 16'(level_q)) >> 8);
    end
`endif

    // Restart overrides any tick/toggle computed above for this cycle.
    if (mode_chg) begin
      mode_d    = mode;
      pre_cnt_d = '0;
      fl_cnt_d  = '0;
      phase_d   = 1'b0;
`ifdef LED_BREATHE_EN
      level_d    = '0;
      br_state_d = BR_UP;
`endif
    end

    sh_r_d = (pwm_cnt_q == 8'hFF) ? duty_r : sh_r_q;
    sh_g_d = (pwm_cnt_q == 8'hFF) ? duty_g : sh_g_q;

    red_d   = 1'b0;
    green_d = 1'b0;
    case (mode_q)
      MODE_OFF: begin
        red_d   = 1'b0;
        green_d = 1'b0;
      end
      MODE_ALT: begin
        red_d   = phase_q & pwm_r;
        green_d = ~phase_q & pwm_g;
      end
      MODE_SYNC: begin
        red_d   = phase_q & pwm_r;
        green_d = phase_q & pwm_g;
      end
      MODE_SOLID: begin
        red_d   = pwm_r;
        green_d = pwm_g;
      end
`ifdef LED_BREATHE_EN
      MODE_BREATHE: begin
        red_d   = pwm_r;
        green_d = pwm_g;
      end
`else
      MODE_BREATHE: begin
        red_d   = 1'b0;
        green_d = 1'b0;
      end
`endif
      default: begin
        red_d   = 1'b0;
        green_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge xclk) begin
    if (sys_rst) begin
      pre_cnt_q  <= '0;
      fl_cnt_q   <= '0;
      pwm_cnt_q  <= '0;
      sh_r_q     <= '0;
      sh_g_q     <= '0;
      mode_q     <= MODE_OFF;
      phase_q    <= 1'b0;
      red_q      <= 1'b0;
      green_q    <= 1'b0;
`ifdef LED_BREATHE_EN
      level_q    <= '0;
      br_state_q <= BR_UP;
`endif
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      sh_r_q     <= sh_r_d;
      sh_g_q     <= sh_g_d;
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      red_q      <= red_d;
      green_q    <= green_d;
`ifdef LED_BREATHE_EN
      level_q    <= level_d;
      br_state_q <= br_state_d;
`endif
    end
  end

  assign red   = red_q;
  assign green = green_q;
  assign phase = phase_q;

endmodule
